gauss_poly_sched: RTL and testbench

Sequencer that drives the Gaussian sampler to build one small polynomial (f or g) for key generation. It pulls 64-bit words from the PRNG stream and pairs them into (r1, r2). It issues G sampler calls per coefficient and sums the returned samples. It then applies the range and parity rejection rules and streams the accepted coefficients out with backpressure.

---
 rtl/gauss_poly_sched_if.sv | 28 ++
 rtl/gauss_poly_sched.sv | 153 +++++++++++++++
 tb/tb_gauss_poly_sched.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gauss_poly_sched_if.sv
// PRNG, sampler and coefficient-stream signals of the Gaussian polynomial scheduler.
// master = scheduler side, slave = PRNG/sampler/consumer side.
interface gauss_poly_sched_if #(
  parameter int LOGN = 9
);
  logic            rng_valid;
  logic            rng_ready;
  logic [63:0]     rng_data;
  logic            smp_valid;
  logic [63:0]     smp_r1;
  logic [63:0]     smp_r2;
  logic            smp_val_valid;
  logic [31:0]     smp_val;
  logic            coef_valid;
  logic            coef_ready;
  logic [LOGN-1:0] coef_idx;
  logic [7:0]      coef_data;

  modport master (
    input  rng_valid, rng_data, smp_val_valid, smp_val, coef_ready,
    output rng_ready, smp_valid, smp_r1, smp_r2, coef_valid, coef_idx, coef_data
  );

  modport slave (
    output rng_valid, rng_data, smp_val_valid, smp_val, coef_ready,
    input  rng_ready, smp_valid, smp_r1, smp_r2, coef_valid, coef_idx, coef_data
  );
endinterface

// File: rtl/gauss_poly_sched.sv
// Builds one keygen polynomial: pairs PRNG words, sums G sampler results per coefficient,
// rejects out-of-range / even-sum coefficients; output held until coef_ready, sampler wait unbounded.
module gauss_poly_sched #(
  parameter int LOGN = 9,
  parameter int LIM  = 127
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [15:0]        rej_cnt,
  gauss_poly_sched_if.master bus
);
  localparam int                 N         = 1 << LOGN;
  localparam int                 G         = 1 << (10 - LOGN);
  localparam logic [9:0]         CALL_LAST = 10'(G - 1);
  localparam logic [LOGN-1:0]    IDX_LAST  = LOGN'(N - 1);
  localparam logic signed [31:0] LIM_S     = 32'(LIM);

  typedef enum logic [2:0] {IDLE, FETCH1, FETCH2, ISSUE, WAIT, CHECK, OUT, DONE} state_t;

  state_t             r_state;
  logic signed [31:0] r_acc;
  logic [9:0]         r_call;
  logic [LOGN-1:0]    r_idx;
  logic               r_parity;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [15:0]        r_rej_cnt;
  logic               r_rng_ready;
  logic               r_smp_valid;
  logic [63:0]        r_r1;
  logic [63:0]        r_r2;
  logic               r_coef_valid;
  logic [LOGN-1:0]    r_coef_idx;
  logic [7:0]         r_coef_data;

  logic w_rng_hs;
  logic w_reject;

  assign w_rng_hs = bus.rng_valid & r_rng_ready;
  // The final coefficient must make the total sum odd.
  assign w_reject = (r_acc > LIM_S) || (r_acc < -LIM_S) ||
                    ((r_idx == IDX_LAST) && !(r_parity ^ r_acc[0]));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_acc        <= '0;
      r_call       <= '0;
      r_idx        <= '0;
      r_parity     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_rej_cnt    <= '0;
      r_rng_ready  <= 1'b0;
      r_smp_valid  <= 1'b0;
      r_r1         <= '0;
      r_r2         <= '0;
      r_coef_valid <= 1'b0;
      r_coef_idx   <= '0;
      r_coef_data  <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state     <= FETCH1;
          r_busy      <= 1'b1;
          r_rng_ready <= 1'b1;
          r_idx       <= '0;
          r_parity    <= 1'b0;
          r_acc       <= '0;
          r_call      <= '0;
          r_rej_cnt   <= '0;
          r_err       <= 1'b0;
        end
        FETCH1: if (w_rng_hs) begin
          r_r1    <= bus.rng_data;
          r_state <= FETCH2;
        end
        FETCH2: if (w_rng_hs) begin
          r_r2        <= bus.rng_data;
          r_rng_ready <= 1'b0;
          r_smp_valid <= 1'b1;
          r_state     <= ISSUE;
        end
        ISSUE: begin
          r_smp_valid <= 1'b0;
          r_state     <= WAIT;
        end
        WAIT: if (bus.smp_val_valid) begin
          r_acc <= r_acc + $signed(bus.smp_val);
          if (r_call == CALL_LAST) begin
            r_state <= CHECK;
          end else begin
            r_call      <= r_call + 10'd1;
            r_rng_ready <= 1'b1;
            r_state     <= FETCH1;
          end
        end
        CHECK: if (w_reject) begin
          if (r_rej_cnt != 16'hFFFF) r_rej_cnt <= r_rej_cnt + 16'd1;
          r_acc       <= '0;
          r_call      <= '0;
          r_rng_ready <= 1'b1;
          r_state     <= FETCH1;
        end else begin
          r_coef_valid <= 1'b1;
          r_coef_data  <= r_acc[7:0];
          r_coef_idx   <= r_idx;
          r_state      <= OUT;
        end
        OUT: if (bus.coef_ready) begin
          r_coef_valid <= 1'b0;
          r_parity     <= r_parity ^ r_acc[0];
          r_acc        <= '0;
          r_call       <= '0;
          if (r_idx == IDX_LAST) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx       <= r_idx + 1'b1;
            r_rng_ready <= 1'b1;
            r_state     <= FETCH1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      // A result arriving while not waiting is dropped but flagged; this wins over a same-cycle start.
      if (bus.smp_val_valid && (r_state != WAIT)) r_err <= 1'b1;
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign err            = r_err;
  assign rej_cnt        = r_rej_cnt;
  assign bus.rng_ready  = r_rng_ready;
  assign bus.smp_valid  = r_smp_valid;
  assign bus.smp_r1     = r_r1;
  assign bus.smp_r2     = r_r2;
  assign bus.coef_valid = r_coef_valid;
  assign bus.coef_idx   = r_coef_idx;
  assign bus.coef_data  = r_coef_data;
endmodule

// File: tb/tb_gauss_poly_sched.sv
// Randomized bench for gauss_poly_sched: PRNG/sampler/consumer agents plus a sum-and-reject reference model.
module tb_gauss_poly_sched;
  localparam int LOGN = 9;
  localparam int N    = 1 << LOGN;
  localparam int G    = 1 << (10 - LOGN);
  localparam logic [63:0] W0 = 64'hA0A1_A2A3_A4A5_A6A7;
  localparam logic [63:0] W1 = 64'hB0B1_B2B3_B4B5_B6B7;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] rej_cnt;

  gauss_poly_sched_if #(.LOGN(LOGN)) bus ();

  gauss_poly_sched #(.LOGN(LOGN)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .err(err), .rej_cnt(rej_cnt), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [63:0] words[$];
  int          samples[$];
  int          obs_idx[$];
  logic [7:0]  obs_dat[$];
  logic [63:0] wq[$];
  int          force_q[$];

  bit   rng_en = 0;
  int   gap_fixed = -1;
  int   gap_left = 0;
  bit   rng_took = 0;
  int   stall_left = 0;
  bit   poke_err = 0;
  int   pend = 0;
  int   calls = 0;
  int   last_calls = 0;
  int   done_cnt = 0;
  int   v_tmp;
  bit   prev_smp = 0, prev_done = 0, prev_stall = 0, prev_chs = 0;
  logic [7:0]      hold_dat;
  logic [LOGN-1:0] hold_idx;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sampler value: forced script first, then an even-sum first try on the last coefficient, else random.
  function automatic int next_sample();
    int p;
    if (force_q.size() > 0) return force_q.pop_front();
    if (obs_idx.size() == N - 1 && last_calls < G) begin
      p = 0;
      foreach (obs_dat[i]) p ^= int'(obs_dat[i][0]);
      last_calls++;
      return (last_calls == 1) ? p : 0;
    end
    if ($urandom_range(0, 15) == 0)
      return ($urandom_range(0, 1) == 1) ? int'($urandom_range(100, 200)) : -int'($urandom_range(100, 200));
    return int'($urandom_range(0, 80)) - 40;
  endfunction

  task automatic clear_run();
    words.delete(); samples.delete(); obs_idx.delete(); obs_dat.delete();
    calls = 0; last_calls = 0; done_cnt = 0;
  endtask

  task automatic chk_idle(input string t);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_done"}, done, 0);
    chk({t, "_err"}, err, 0);
    chk({t, "_rej"}, rej_cnt, 0);
    chk({t, "_rng_rdy"}, bus.rng_ready, 0);
    chk({t, "_smp_v"}, bus.smp_valid, 0);
    chk({t, "_coef_v"}, bus.coef_valid, 0);
    chk({t, "_coef_i"}, bus.coef_idx, 0);
    chk({t, "_coef_d"}, bus.coef_data, 0);
    chk({t, "_r1"}, bus.smp_r1, 0);
    chk({t, "_r2"}, bus.smp_r2, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string t);
    int n = 0;
    while (done_cnt < 1 && n < 30000) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    chk({t, "_done_cnt"}, done_cnt, 1);
    chk({t, "_idle_busy"}, busy, 0);
    chk({t, "_err"}, err, 0);
  endtask

  // Reference: every G consecutive samples form one attempt; apply range and odd-total rules.
  task automatic check_run(input string t);
    int k = 0, idx = 0, par = 0, rej = 0, sum;
    int e_idx[$];
    logic [7:0] e_dat[$];
    while (idx < N && k + G <= samples.size()) begin
      sum = 0;
      for (int j = 0; j < G; j++) sum += samples[k + j];
      k += G;
      if (sum > 127 || sum < -127 || (idx == N - 1 && ((par + sum) & 1) == 0)) rej++;
      else begin
        e_idx.push_back(idx); e_dat.push_back(sum[7:0]);
        par ^= sum & 1; idx++;
      end
    end
    chk({t, "_ncoef"}, obs_idx.size(), N);
    chk({t, "_model_ncoef"}, obs_idx.size(), e_idx.size());
    chk({t, "_nsamp"}, samples.size(), k);
    chk({t, "_rej"}, rej_cnt, rej);
    for (int i = 0; i < obs_idx.size() && i < e_idx.size(); i++) begin
      if (n_fail > 40) break;
      chk({t, "_idx"}, obs_idx[i], e_idx[i]);
      chk({t, "_dat"}, obs_dat[i], e_dat[i]);
    end
  endtask

  // Agents: inputs change on the falling edge, handshakes are judged against what the next rising edge sees.
  initial begin
    bus.rng_valid = 1'b0; bus.rng_data = '0; bus.smp_val_valid = 1'b0;
    bus.smp_val = '0; bus.coef_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.smp_val_valid = 1'b0;
      if (rst) begin
        if (pend > 0) begin bus.smp_val_valid = 1'b1; bus.smp_val = 32'h7FFF_0000; end
        pend = 0; bus.rng_valid = 1'b0; rng_took = 0; bus.coef_ready = 1'b0;
        prev_smp = 0; prev_done = 0; prev_stall = 0; prev_chs = 0;
        continue;
      end
      if (poke_err) begin bus.smp_val_valid = 1'b1; bus.smp_val = 32'd5; poke_err = 0; end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          v_tmp = next_sample();
          bus.smp_val_valid = 1'b1; bus.smp_val = v_tmp; samples.push_back(v_tmp);
        end
      end
      if (bus.smp_valid) begin
        chk("smp_valid_1cyc", prev_smp, 0);
        if (!prev_smp) begin
          if (words.size() >= 2 * calls + 2) begin
            chk("smp_r1", bus.smp_r1, words[2 * calls]);
            chk("smp_r2", bus.smp_r2, words[2 * calls + 1]);
          end else chk("rng_words", words.size(), 2 * calls + 2);
          calls++;
          pend = $urandom_range(1, 3);
        end
      end
      prev_smp = bus.smp_valid;

      if (rng_took) begin
        bus.rng_valid = 1'b0; rng_took = 0;
        gap_left = (gap_fixed >= 0) ? gap_fixed : int'($urandom_range(0, 2));
      end
      if (!bus.rng_valid && rng_en) begin
        if (gap_left > 0) gap_left--;
        else begin
          bus.rng_valid = 1'b1;
          if (wq.size() > 0) bus.rng_data = wq.pop_front();
          else bus.rng_data = {$urandom, $urandom};
        end
      end
      if (bus.rng_valid && bus.rng_ready) begin words.push_back(bus.rng_data); rng_took = 1; end

      if (prev_chs) chk("coef_drop", bus.coef_valid, 0);
      if (prev_stall) begin
        chk("coef_hold_v", bus.coef_valid, 1);
        chk("coef_hold_d", bus.coef_data, hold_dat);
        chk("coef_hold_i", bus.coef_idx, hold_idx);
      end
      if (bus.coef_valid) begin
        chk("out_rng_rdy", bus.rng_ready, 0);
        chk("out_smp_v", bus.smp_valid, 0);
        if (stall_left > 0) begin bus.coef_ready = 1'b0; stall_left--; end
        else bus.coef_ready = ($urandom_range(0, 3) != 0);
      end else bus.coef_ready = ($urandom_range(0, 1) != 0);
      prev_stall = bus.coef_valid && !bus.coef_ready;
      prev_chs   = bus.coef_valid && bus.coef_ready;
      hold_dat = bus.coef_data; hold_idx = bus.coef_idx;
      if (prev_chs) begin obs_idx.push_back(int'(bus.coef_idx)); obs_dat.push_back(bus.coef_data); end

      if (prev_done) begin chk("done_pulse", done, 0); chk("busy_after_done", busy, 0); end
      if (done) begin chk("busy_at_done", busy, 1); done_cnt++; end
      prev_done = done;
    end
  end

  initial begin
    int  n;
    bit  dropped;
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); chk_idle("rst");
    @(posedge clk); #1 rst = 1'b0;

    // Directed opening: gapped W0/W1, forced sums 200 (reject) then 70, 5-cycle OUT stall.
    clear_run();
    force_q = '{100, 100, 100, -30};
    wq = '{W0, W1};
    gap_fixed = 3; gap_left = 3; stall_left = 5; rng_en = 1;
    pulse_start();
    n = 0; dropped = 0;
    while (!bus.smp_valid && n < 200) begin
      @(negedge clk);
      if (!bus.smp_valid && !bus.rng_ready) dropped = 1;
      n++;
    end
    chk("A_issue", bus.smp_valid, 1);
    chk("A_rdy_through_gap", dropped, 0);
    chk("A_r1", bus.smp_r1, W0);
    chk("A_r2", bus.smp_r2, W1);
    gap_fixed = -1;
    n = 0;
    while (obs_idx.size() < 1 && n < 500) begin @(negedge clk); n++; end
    chk("A_first_coef", obs_idx.size(), 1);
    if (obs_idx.size() >= 1) begin
      chk("A_idx0", obs_idx[0], 0);
      chk("A_dat0", obs_dat[0], 8'h46);
    end
    chk("A_rej", rej_cnt, 1);
    chk("A_calls", samples.size(), 4);

    // Reset while waiting on the sampler; its late result lands during reset.
    n = 0;
    while (obs_idx.size() < 5 && n < 3000) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.smp_valid && n < 200);
    chk("M_issue", bus.smp_valid, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    clear_run();
    @(negedge clk); chk_idle("rst_mid");
    repeat (3) @(negedge clk);
    chk("B_idle_err", err, 0);

    @(posedge clk); #1 pulse_start();
    wait_done("B");
    check_run("B");

    // Stray sampler result in IDLE sets a sticky err that the next start clears.
    @(posedge clk); #1 poke_err = 1;
    repeat (3) @(negedge clk);
    chk("C_err_set", err, 1);
    repeat (5) @(negedge clk);
    chk("C_err_sticky", err, 1);
    @(posedge clk); #1 clear_run();
    pulse_start();
    @(negedge clk);
    chk("C_err_clr", err, 0);
    chk("C_rej_clr", rej_cnt, 0);
    chk("C_busy", busy, 1);
    wait_done("C");
    check_run("C");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
